// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and latency defaults for the MDU
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational mult/div datapath producing the full {hi,lo} result
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_result
);

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic signed [31:0] w_rs_s;
  logic signed [31:0] w_rt_s;
  logic signed [31:0] w_rt_safe_s;
  logic        [31:0] w_rt_safe_u;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quo_u;
  logic        [31:0] w_rem_u;
  logic               w_div_zero;
  logic               w_div_ovf;

  assign w_prod_s = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  assign w_rs_s     = $signed(i_rs);
  assign w_rt_s     = $signed(i_rt);
  assign w_div_zero = (i_rt == 32'd0);
  assign w_div_ovf  = (i_rs == 32'h8000_0000) && (i_rt == 32'hFFFF_FFFF);

  // Dividing by 1 instead of -1 on overflow yields exactly q=0x80000000, r=0,
  // and a zero divisor never reaches the divider because its result is discarded.
  assign w_rt_safe_s = (w_div_zero || w_div_ovf) ? 32'sd1 : w_rt_s;
  assign w_rt_safe_u = w_div_zero ? 32'd1 : i_rt;

  assign w_quo_s = w_rs_s / w_rt_safe_s;
  assign w_rem_s = w_rs_s % w_rt_safe_s;
  assign w_quo_u = i_rs / w_rt_safe_u;
  assign w_rem_u = i_rs % w_rt_safe_u;

  always_comb begin
    o_result = {i_hi, i_lo};
    case (i_op)
      MD_MULT:  o_result = w_prod_s;
      MD_MULTU: o_result = w_prod_u;
      MD_DIV:   if (!w_div_zero) o_result = {w_rem_s, w_quo_s};
      MD_DIVU:  if (!w_div_zero) o_result = {w_rem_u, w_quo_u};
      default:  o_result = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer: busy counter, pending result shadow and HI/LO registers
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic [31:0]      w_pend_hi_nxt;
  logic [31:0]      w_pend_lo_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic [63:0]      w_result;

  mdu_arith u_arith (
    .i_op     (md_op),
    .i_rs     (rs_val),
    .i_rt     (rt_val),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_result (w_result)
  );

  assign busy  = (r_state == ST_BUSY);
  assign start = md_valid & is_arith_op(md_op) & ~busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Any md_valid seen in BUSY falls through the defaults and changes nothing.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_pend_hi_nxt = w_result[63:32];
          w_pend_lo_nxt = w_result[31:0];
          w_cnt_nxt     = is_div_op(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          w_state_nxt   = ST_BUSY;
        end else if (md_valid && (md_op == MD_MTHI)) begin
          w_hi_nxt = rs_val;
        end else if (md_valid && (md_op == MD_MTLO)) begin
          w_lo_nxt = rs_val;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
      r_done    <= w_done_nxt;
    end
  end

endmodule
